instruction_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory interface.
- Holds the program counter and drives a word-aligned fetch address to the combinational 128-word instruction memory, which returns the instruction in the same cycle.
- Captures the returned instruction and its PC+4 into the IF/ID pipeline register.
- Handles pipeline stall, branch/jump redirect with bubble insertion, and a misaligned-target fault halt.

---
 rtl/mips_pkg.sv | 13 +
 rtl/pc_register.sv | 22 ++
 rtl/instruction_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the instruction fetch slice.
// Holds the nop encoding, word size and fetch FSM state type.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } ifu_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter register with synchronous reset and load enable.
// Ports: Clk, Reset (sync, active-high), Enable (load when 1),
//        Next (value to load), PC (current program counter).
module pc_register #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Enable,
    input  logic [31:0] Next,
    output logic [31:0] PC
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC <= RESET_PC;
        end else if (Enable) begin
            PC <= Next;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC, IF/ID register, stall/redirect/fault FSM.
// Ports: Clk, Reset (sync, active-high); ImemAddress/ImemInstruction to
//   the combinational instruction memory; Stall, Redirect, RedirectTarget
//   from later stages; IfIdInstruction, IfIdPCPlus4, IfIdValid to decode;
//   FetchFault (sticky misaligned-target flag).
// Optional macro IFU_PERF_COUNTERS_EN adds FetchCount and StallCount.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          IMEM_ADDR_BITS = 7
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] IfIdInstruction,
    output logic [31:0] IfIdPCPlus4,
    output logic        IfIdValid,
    output logic        FetchFault
`ifdef IFU_PERF_COUNTERS_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
`endif
);

    ifu_state_t  state_q;
    ifu_state_t  state_d;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_en;
    logic [31:0] pc_next;

    logic [31:0] instr_d;
    logic [31:0] pc4_d;
    logic        valid_d;
    logic        fault_d;
    logic        fetch_inc;
    logic        stall_inc;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .Clk    (Clk),
        .Reset  (Reset),
        .Enable (pc_en),
        .Next   (pc_next),
        .PC     (pc)
    );

    assign ImemAddress = pc;
    // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 gives 0.
    assign pc_plus4 = pc + WORD_BYTES;

    always_comb begin
        state_d   = state_q;
        pc_en     = 1'b0;
        pc_next   = pc_plus4;
        instr_d   = IfIdInstruction;
        pc4_d     = IfIdPCPlus4;
        valid_d   = IfIdValid;
        fault_d   = FetchFault;
        fetch_inc = 1'b0;
        stall_inc = 1'b0;
        unique case (state_q)
            RUN: begin
                if (Redirect) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    if (RedirectTarget[1:0] == 2'b00) begin
                        pc_en   = 1'b1;
                        pc_next = RedirectTarget;
                    end else begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end
                end else if (Stall) begin
                    stall_inc = 1'b1;
                end else begin
                    pc_en     = 1'b1;
                    instr_d   = ImemInstruction;
                    pc4_d     = pc_plus4;
                    valid_d   = 1'b1;
                    fetch_inc = 1'b1;
                end
            end
            HALT: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q         <= RUN;
            IfIdInstruction <= NOP_INSTR;
            IfIdPCPlus4     <= 32'h0;
            IfIdValid       <= 1'b0;
            FetchFault      <= 1'b0;
        end else begin
            state_q         <= state_d;
            IfIdInstruction <= instr_d;
            IfIdPCPlus4     <= pc4_d;
            IfIdValid       <= valid_d;
            FetchFault      <= fault_d;
        end
    end

    // The memory index must fit above the two byte-offset bits.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            assert (IMEM_ADDR_BITS >= 1 && IMEM_ADDR_BITS <= 30);
        end
    end

`ifdef IFU_PERF_COUNTERS_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            FetchCount <= 32'h0;
            StallCount <= 32'h0;
        end else begin
            if (fetch_inc) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (stall_inc) begin
                StallCount <= StallCount + 32'd1;
            end
        end
    end
`else
    logic unused_perf;
    assign unused_perf = fetch_inc ^ stall_inc;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
// Models the 128-word combinational memory aliased on Address[8:2].
module tb_instruction_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] IfIdInstruction;
    logic [31:0] IfIdPCPlus4;
    logic        IfIdValid;
    logic        FetchFault;
`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] FetchCount;
    logic [31:0] StallCount;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [128];

    instruction_fetch_unit dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .ImemAddress     (ImemAddress),
        .ImemInstruction (ImemInstruction),
        .Stall           (Stall),
        .Redirect        (Redirect),
        .RedirectTarget  (RedirectTarget),
        .IfIdInstruction (IfIdInstruction),
        .IfIdPCPlus4     (IfIdPCPlus4),
        .IfIdValid       (IfIdValid),
        .FetchFault      (FetchFault)
`ifdef IFU_PERF_COUNTERS_EN
        ,
        .FetchCount      (FetchCount),
        .StallCount      (StallCount)
`endif
    );

    assign ImemInstruction = mem[ImemAddress[8:2]];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] memval(input int i);
        if (i == 1)  return 32'h2008_0000;
        if (i == 61) return 32'h0800_0001;
        return 32'hA000_0000 + i;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_ifid(input string name, input logic [31:0] addr,
                            input logic [31:0] instr, input logic [31:0] pc4,
                            input logic valid);
        chk({name, ".addr"}, ImemAddress, addr);
        chk({name, ".instr"}, IfIdInstruction, instr);
        chk({name, ".pc4"}, IfIdPCPlus4, pc4);
        chk({name, ".valid"}, {31'h0, IfIdValid}, {31'h0, valid});
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Stall = 1'b1;
        Redirect = 1'b1;
        RedirectTarget = 32'h0000_0080;
        Reset = 1'b1;
        step();
        Stall = 1'b0;
        Redirect = 1'b0;
        Reset = 1'b0;
        chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("reset.fault", {31'h0, FetchFault}, 32'h0);
    endtask

    task automatic test_fetch();
        chk("fetch0.addr", ImemAddress, 32'h0);
        step();
        chk_ifid("fetch1", 32'h4, memval(0), 32'h4, 1'b1);
        step();
        chk_ifid("fetch2", 32'h8, 32'h2008_0000, 32'h8, 1'b1);
        step();
        chk("fetch3.addr", ImemAddress, 32'hC);
        step();
        chk("fetch4.addr", ImemAddress, 32'h10);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) step();
        chk_ifid("pre_stall", 32'h1C, memval(6), 32'h1C, 1'b1);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ifid("stall", 32'h1C, memval(6), 32'h1C, 1'b1);
        end
        Stall = 1'b0;
        step();
        chk_ifid("stall_release", 32'h20, memval(7), 32'h20, 1'b1);
    endtask

    task automatic test_redirect();
        Redirect = 1'b1;
        RedirectTarget = 32'h0000_00F4;
        step();
        Redirect = 1'b0;
        chk_ifid("redir_f4", 32'hF4, 32'h0, 32'h20, 1'b0);
        step();
        chk_ifid("fetch_j", 32'hF8, 32'h0800_0001, 32'hF8, 1'b1);
        Redirect = 1'b1;
        RedirectTarget = 32'h0000_0004;
        step();
        Redirect = 1'b0;
        chk_ifid("jump_bubble", 32'h4, 32'h0, 32'hF8, 1'b0);
        step();
        chk_ifid("jump_target", 32'h8, 32'h2008_0000, 32'h8, 1'b1);
    endtask

    task automatic test_redirect_stall();
        Redirect = 1'b1;
        Stall = 1'b1;
        RedirectTarget = 32'h0000_0040;
        step();
        Redirect = 1'b0;
        Stall = 1'b0;
        chk_ifid("redir_stall", 32'h40, 32'h0, 32'h8, 1'b0);
        step();
        chk_ifid("after_rs", 32'h44, memval(16), 32'h44, 1'b1);
    endtask

    task automatic test_fault();
        Redirect = 1'b1;
        RedirectTarget = 32'h0000_0042;
        step();
        chk_ifid("fault", 32'h44, 32'h0, 32'h44, 1'b0);
        chk("fault.flag", {31'h0, FetchFault}, 32'h1);
        RedirectTarget = 32'h0000_0100;
        for (int i = 0; i < 10; i++) begin
            Stall = i[0];
            step();
            chk_ifid("halt", 32'h44, 32'h0, 32'h44, 1'b0);
            chk("halt.flag", {31'h0, FetchFault}, 32'h1);
        end
        Stall = 1'b1;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        Stall = 1'b0;
        Redirect = 1'b0;
        chk_ifid("fault_reset", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("fault_reset.flag", {31'h0, FetchFault}, 32'h0);
        step();
        chk_ifid("fault_resume", 32'h4, memval(0), 32'h4, 1'b1);
    endtask

    task automatic test_wrap();
        Redirect = 1'b1;
        RedirectTarget = 32'hFFFF_FFFC;
        step();
        Redirect = 1'b0;
        chk("wrap.addr", ImemAddress, 32'hFFFF_FFFC);
        step();
        chk_ifid("wrap", 32'h0, memval(127), 32'h0, 1'b1);
    endtask

`ifdef IFU_PERF_COUNTERS_EN
    task automatic test_perf();
        do_reset();
        chk("perf.reset_fetch", FetchCount, 32'd0);
        chk("perf.reset_stall", StallCount, 32'd0);
        for (int i = 0; i < 5; i++) step();
        Stall = 1'b1;
        step();
        step();
        Stall = 1'b0;
        Redirect = 1'b1;
        RedirectTarget = 32'h0000_0010;
        step();
        Redirect = 1'b0;
        chk("perf.fetch", FetchCount, 32'd5);
        chk("perf.stall", StallCount, 32'd2);
    endtask
`endif

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = memval(i);
        Reset = 1'b0;
        Stall = 1'b0;
        Redirect = 1'b0;
        RedirectTarget = 32'h0;
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_fault();
        test_wrap();
`ifdef IFU_PERF_COUNTERS_EN
        test_perf();
`endif
        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
